clint: RTL and testbench

Core-local interruptor for the RV32 machine-mode core. It holds the memory-mapped `msip`, `mtime` and `mtimecmp` registers and drives the `msip`, `mtip` and `mtime[63:0]` inputs of the CSR unit. Software reaches it through a single-cycle-latency slave port on the data bus. It is the upstream source of the machine timer and software interrupts that the CSR unit samples into `mip`.

---
 rtl/clint.sv | 115 +++++++++++
 tb/tb_clint.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip, mtime and mtimecmp registers
// behind a single-cycle slave port, driving msip/mtip/mtime to the CSR unit.
module clint #(
    parameter logic [31:0] clint_base = 32'h0200_0000,
    parameter int unsigned rtc_div    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam logic [15:0] cnt_max = 16'(rtc_div - 1);

    logic        msip_q, msip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        mtip_q;

    logic [31:0] offset;
    logic        in_range;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic        wr_en;
    logic        tick;
    logic [31:0] rd_word;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

    // Decode is done on the offset so that addresses below the base wrap
    // to a large value and fall outside the 64 KiB window.
    assign offset      = clint_addr - clint_base;
    assign in_range    = (offset[31:16] == 16'h0000);
    assign sel_msip    = in_range && (offset[15:0] == 16'h0000);
    assign sel_cmp_lo  = in_range && (offset[15:0] == 16'h4000);
    assign sel_cmp_hi  = in_range && (offset[15:0] == 16'h4004);
    assign sel_time_lo = in_range && (offset[15:0] == 16'hBFF8);
    assign sel_time_hi = in_range && (offset[15:0] == 16'hBFFC);

    assign wr_en = clint_valid && !clint_instr && (clint_wstrb != 4'b0000);
    assign tick  = (cnt_q == cnt_max);

    always_comb begin
        rd_word = 32'h0000_0000;
        if (sel_msip)    rd_word = {31'b0, msip_q};
        if (sel_cmp_lo)  rd_word = mtimecmp_q[31:0];
        if (sel_cmp_hi)  rd_word = mtimecmp_q[63:32];
        if (sel_time_lo) rd_word = mtime_q[31:0];
        if (sel_time_hi) rd_word = mtime_q[63:32];
    end

    // A software write to either mtime half overrides the tick of that cycle.
    always_comb begin
        cnt_d      = tick ? 16'h0000 : cnt_q + 16'h0001;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        if (wr_en && sel_msip && clint_wstrb[0]) msip_d = clint_wdata[0];
        if (wr_en && sel_cmp_lo)
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
        if (wr_en && sel_cmp_hi)
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
        if (wr_en && sel_time_lo)
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
        if (wr_en && sel_time_hi)
            mtime_d = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb), mtime_q[31:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            msip_q     <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            cnt_q      <= 16'h0000;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            mtip_q     <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            cnt_q      <= cnt_d;
            ready_q    <= clint_valid;
            rdata_q    <= clint_valid ? rd_word : 32'h0000_0000;
            mtip_q     <= (mtime_q >= mtimecmp_q);
        end
    end

    assign clint_ready = ready_q;
    assign clint_rdata = rdata_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: two instances (rtc_div 1 and 4) share the bus
// inputs; expected read data is queued at issue and checked on clint_ready.
module tb_clint;

    localparam logic [31:0] base_addr = 32'h0200_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid_a, valid_b, instr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, msip_a, msip_b, mtip_a, mtip_b;
    logic [63:0] mtime_a, mtime_b;

    clint #(.clint_base(base_addr), .rtc_div(1)) dut_a (
        .clk(clk), .rst(rst), .clint_valid(valid_a), .clint_instr(instr),
        .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
        .clint_rdata(rdata_a), .clint_ready(ready_a), .clint_msip(msip_a),
        .clint_mtip(mtip_a), .clint_mtime(mtime_a)
    );

    clint #(.clint_base(base_addr), .rtc_div(4)) dut_b (
        .clk(clk), .rst(rst), .clint_valid(valid_b), .clint_instr(instr),
        .clint_addr(addr), .clint_wdata(wdata), .clint_wstrb(wstrb),
        .clint_rdata(rdata_b), .clint_ready(ready_b), .clint_msip(msip_b),
        .clint_mtip(mtip_b), .clint_mtime(mtime_b)
    );

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    bit   found;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one request for a single cycle and queues its expected response.
    task automatic applyStimulus(input bit which, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input bit ins, input bit chk,
                                 input logic [31:0] exp_data);
        exp_t e;
        e.chk  = chk;
        e.data = exp_data;
        e.due  = cycle + 1;
        addr   = a;
        wdata  = d;
        wstrb  = s;
        instr  = ins;
        if (which) begin
            valid_b = 1'b1;
            exp_b.push_back(e);
        end else begin
            valid_a = 1'b1;
            exp_a.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        instr   = 1'b0;
        wstrb   = 4'h0;
    endtask

    task automatic rd(input bit which, input logic [31:0] off, input logic [31:0] exp_data);
        applyStimulus(which, base_addr + off, 32'h0, 4'h0, 1'b0, 1'b1, exp_data);
    endtask

    task automatic wr(input bit which, input logic [31:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        applyStimulus(which, base_addr + off, d, s, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ready_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready_a: got ready=1, expected ready=0");
            end else begin
                mon_e = exp_a.pop_front();
                checkOutput("ready_timing_a", 64'(cycle), 64'(mon_e.due));
                if (mon_e.chk) checkOutput("rdata_a", {32'h0, rdata_a}, {32'h0, mon_e.data});
            end
        end else begin
            checkOutput("idle_rdata_a", {32'h0, rdata_a}, 64'h0);
        end
        if (ready_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready_b: got ready=1, expected ready=0");
            end else begin
                mon_e = exp_b.pop_front();
                checkOutput("ready_timing_b", 64'(cycle), 64'(mon_e.due));
                if (mon_e.chk) checkOutput("rdata_b", {32'h0, rdata_b}, {32'h0, mon_e.data});
            end
        end else begin
            checkOutput("idle_rdata_b", {32'h0, rdata_b}, 64'h0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        instr   = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;
        wstrb   = 4'h0;
        idle(3);
        checkOutput("reset_mtime_a", mtime_a, 64'd0);
        checkOutput("reset_mtime_b", mtime_b, 64'd0);
        checkOutput("reset_mtip_a", 64'(mtip_a), 64'd0);
        checkOutput("reset_msip_a", 64'(msip_a), 64'd0);
        checkOutput("reset_ready_a", 64'(ready_a), 64'd0);

        // Free-running mtime after reset.
        rst = 1'b1;
        idle(10);
        checkOutput("idle_mtime_a", mtime_a, 64'd10);
        checkOutput("idle_mtime_b", mtime_b, 64'd2);
        checkOutput("idle_mtip_a", 64'(mtip_a), 64'd0);
        checkOutput("idle_msip_a", 64'(msip_a), 64'd0);
        checkOutput("idle_ready_a", 64'(ready_a), 64'd0);

        // msip writes, strobes and instruction-fetch requests.
        wr(0, 32'h0, 32'hFFFF_FFFF, 4'hF);
        checkOutput("msip_set", 64'(msip_a), 64'd1);
        rd(0, 32'h0, 32'h1);
        wr(0, 32'h0, 32'h0, 4'hF);
        checkOutput("msip_clear", 64'(msip_a), 64'd0);
        wr(0, 32'h0, 32'h1, 4'b1110);
        checkOutput("msip_lane0_off", 64'(msip_a), 64'd0);
        applyStimulus(0, base_addr, 32'h1, 4'hF, 1'b1, 1'b1, 32'h0);
        checkOutput("msip_instr_nowrite", 64'(msip_a), 64'd0);
        wr(0, 32'h0, 32'h1, 4'b0001);
        checkOutput("msip_lane0_on", 64'(msip_a), 64'd1);
        rd(0, 32'h0, 32'h1);

        // Timer compare with rtc_div = 4.
        wr(1, 32'hBFF8, 32'h0, 4'hF);
        wr(1, 32'h4000, 32'h5, 4'hF);
        wr(1, 32'h4004, 32'h0, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (mtime_b == 64'd5) begin
                found = 1'b1;
                break;
            end
            idle(1);
        end
        checkOutput("mtime_b_reach5", 64'(found), 64'd1);
        if (found) begin
            checkOutput("mtip_b_before", 64'(mtip_b), 64'd0);
            idle(1);
            checkOutput("mtip_b_rise", 64'(mtip_b), 64'd1);
        end
        wr(1, 32'h4004, 32'h1, 4'hF);
        checkOutput("mtip_b_hold", 64'(mtip_b), 64'd1);
        idle(1);
        checkOutput("mtip_b_drop", 64'(mtip_b), 64'd0);
        rd(1, 32'h4000, 32'h5);
        rd(1, 32'h4004, 32'h1);

        // mtime wrap; the low-word write lands in a tick cycle and wins.
        wr(0, 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(0, 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
        checkOutput("wrap_written", mtime_a, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("wrap_mtip0", 64'(mtip_a), 64'd0);
        rd(0, 32'hBFF8, 32'hFFFF_FFFE);
        checkOutput("wrap_allones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("wrap_mtip1", 64'(mtip_a), 64'd0);
        rd(0, 32'hBFFC, 32'hFFFF_FFFF);
        checkOutput("wrap_zero", mtime_a, 64'd0);
        checkOutput("wrap_mtip_pulse", 64'(mtip_a), 64'd1);
        rd(0, 32'hBFF8, 32'h0);
        checkOutput("wrap_one", mtime_a, 64'd1);
        checkOutput("wrap_mtip_end", 64'(mtip_a), 64'd0);
        rd(0, 32'hBFFC, 32'h0);

        // Back-to-back mtimecmp access and unmapped addresses.
        rd(0, 32'h4000, 32'hFFFF_FFFF);
        wr(0, 32'h4000, 32'h1234_5678, 4'hF);
        rd(0, 32'h4000, 32'h1234_5678);
        applyStimulus(0, base_addr + 32'h4000, 32'h0, 4'hF, 1'b1, 1'b1, 32'h1234_5678);
        rd(0, 32'h1000, 32'h0);
        wr(0, 32'h1000, 32'hDEAD_BEEF, 4'hF);
        rd(0, 32'h1000, 32'h0);
        rd(0, 32'h1_4000, 32'h0);
        rd(0, 32'h4004, 32'hFFFF_FFFF);

        // Reset with a read in flight: the response must be dropped.
        wr(1, 32'h4004, 32'h0, 4'hF);
        idle(1);
        checkOutput("pre_reset_mtip_b", 64'(mtip_b), 64'd1);
        addr    = base_addr + 32'h4000;
        valid_a = 1'b1;
        rst     = 1'b0;
        idle(1);
        valid_a = 1'b0;
        checkOutput("rst_ready_a", 64'(ready_a), 64'd0);
        checkOutput("rst_mtime_a", mtime_a, 64'd0);
        checkOutput("rst_msip_a", 64'(msip_a), 64'd0);
        checkOutput("rst_mtip_b", 64'(mtip_b), 64'd0);
        checkOutput("rst_mtime_b", mtime_b, 64'd0);
        idle(1);
        rst = 1'b1;
        rd(0, 32'h4000, 32'hFFFF_FFFF);
        rd(0, 32'h0, 32'h0);
        rd(1, 32'h4004, 32'hFFFF_FFFF);

        idle(3);
        checkOutput("pending_a", 64'(exp_a.size()), 64'd0);
        checkOutput("pending_b", 64'(exp_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
